scalable_mac: RTL and testbench

SCALABLE_MAC -- requirements
Module: scalable_mac

---
 rtl/scalable_mac_pkg.sv | 21 ++
 rtl/scalable_mult.sv | 58 +++++
 rtl/scalable_mac.sv | 148 ++++++++++++++
 tb/tb_scalable_mac.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/scalable_mac_pkg.sv
// Shared types for the scalable MAC: precision mode encodings and lane-count helper.
package scalable_mac_pkg;

  typedef enum logic [1:0] {
    MODE_FULL      = 2'b00,
    MODE_QUARTER   = 2'b01,
    MODE_HALF      = 2'b10,
    MODE_QUARTER_X = 2'b11
  } mode_e;

  localparam int unsigned NUM_PRECISIONS = 3;

  function automatic int unsigned lane_count(input mode_e m);
    case (m)
      MODE_FULL: lane_count = 1;
      MODE_HALF: lane_count = 2;
      default:   lane_count = 4;
    endcase
  endfunction

endpackage

// File: rtl/scalable_mult.sv
// Combinational lane-split signed multiplier; each lane product is sign-extended
// into its ACC_WIDTH/L slot of the packed result.
module scalable_mult
  import scalable_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  mode_e                 mode_i,
  output logic [ACC_WIDTH-1:0]  prod_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam int QW = DATA_WIDTH / 4;
  localparam int HA = ACC_WIDTH / 2;
  localparam int QA = ACC_WIDTH / 4;

  logic signed [PW-1:0] full_p;
  logic [ACC_WIDTH-1:0] full_x;
  logic [ACC_WIDTH-1:0] half_x;
  logic [ACC_WIDTH-1:0] quar_x;

  assign full_p = PW'($signed(a_i)) * PW'($signed(b_i));
  assign full_x = ACC_WIDTH'(full_p);

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    logic signed [HW-1:0]         ha;
    logic signed [HW-1:0]         hb;
    logic signed [DATA_WIDTH-1:0] hp;
    assign ha = a_i[gi*HW +: HW];
    assign hb = b_i[gi*HW +: HW];
    assign hp = DATA_WIDTH'(ha) * DATA_WIDTH'(hb);
    assign half_x[gi*HA +: HA] = HA'(hp);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_quar
    logic signed [QW-1:0] qa;
    logic signed [QW-1:0] qb;
    logic signed [HW-1:0] qp;
    assign qa = a_i[gi*QW +: QW];
    assign qb = b_i[gi*QW +: QW];
    assign qp = HW'(qa) * HW'(qb);
    assign quar_x[gi*QA +: QA] = QA'(qp);
  end

  always_comb begin
    prod_o = quar_x;
    case (mode_i)
      MODE_FULL: prod_o = full_x;
      MODE_HALF: prod_o = half_x;
      default:   prod_o = quar_x;
    endcase
  end

endmodule

// File: rtl/scalable_mac.sv
// Two-stage lane-configurable multiply-accumulate with valid/ready handshakes.
// Define SCALABLE_MAC_SATURATE_EN to clamp each lane instead of wrapping.
module scalable_mac
  import scalable_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [1:0]            mode_i,
  input  logic                  last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [ACC_WIDTH-1:0]  out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  logic                 first_q, first_d;
  mode_e                mode_q, mode_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  mode_e                s1_mode_q, s1_mode_d;
  logic [ACC_WIDTH-1:0] s1_prod_q, s1_prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  logic                 stall;
  logic                 accept;
  mode_e                eff_mode;
  logic [ACC_WIDTH-1:0] prod_c;
  logic [NUM_PRECISIONS-1:0][ACC_WIDTH-1:0] sum_c;
  logic [ACC_WIDTH-1:0] sum_sel;

  assign stall       = out_valid_q & ~out_ready_i;
  assign in_ready_o  = ~stall;
  assign accept      = in_valid_i & in_ready_o;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  // The first beat of an accumulation picks the precision; later beats reuse it.
  assign eff_mode = first_q ? mode_e'(mode_i) : mode_q;

  scalable_mult #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mult (
    .a_i   (a_i),
    .b_i   (b_i),
    .mode_i(eff_mode),
    .prod_o(prod_c)
  );

  // Candidate sums for every precision; index mi has 2**mi lanes.
  for (genvar mi = 0; mi < NUM_PRECISIONS; mi++) begin : g_prec
    localparam int LW = ACC_WIDTH >> mi;
    for (genvar gi = 0; gi < (1 << mi); gi++) begin : g_lane
      logic [LW-1:0] lane_acc;
      logic [LW-1:0] lane_prod;
      logic [LW-1:0] lane_sum;
      assign lane_acc  = acc_q[gi*LW +: LW];
      assign lane_prod = s1_prod_q[gi*LW +: LW];
      assign lane_sum  = lane_acc + lane_prod;
`ifdef SCALABLE_MAC_SATURATE_EN
      logic lane_ovf;
      assign lane_ovf = (lane_acc[LW-1] == lane_prod[LW-1]) &&
                        (lane_sum[LW-1] != lane_acc[LW-1]);
      assign sum_c[mi][gi*LW +: LW] = !lane_ovf      ? lane_sum :
                                      lane_acc[LW-1] ? {1'b1, {(LW-1){1'b0}}} :
                                                       {1'b0, {(LW-1){1'b1}}};
`else
      assign sum_c[mi][gi*LW +: LW] = lane_sum;
`endif
    end
  end

  always_comb begin
    sum_sel = sum_c[2];
    case (s1_mode_q)
      MODE_FULL: sum_sel = sum_c[0];
      MODE_HALF: sum_sel = sum_c[1];
      default:   sum_sel = sum_c[2];
    endcase
  end

  always_comb begin
    first_d     = first_q;
    mode_d      = mode_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    s1_prod_d   = s1_prod_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      first_d = last_i;
      if (first_q) mode_d = mode_e'(mode_i);
    end

    if (!stall) begin
      s1_valid_d  = accept;
      s1_last_d   = last_i;
      s1_mode_d   = eff_mode;
      s1_prod_d   = prod_c;
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_data_d  = sum_sel;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = sum_sel;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q     <= 1'b1;
      mode_q      <= MODE_FULL;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= MODE_FULL;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      first_q     <= first_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s1_prod_q   <= s1_prod_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_scalable_mac.sv
// Directed bench for scalable_mac (DATA_WIDTH=8, ACC_WIDTH=32): single-beat vector
// table plus accumulation, backpressure and mid-accumulation reset sequences.
module tb_scalable_mac;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  mode;
  logic        last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  scalable_mac #(
    .DATA_WIDTH(8),
    .ACC_WIDTH (32)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .a_i        (a),
    .b_i        (b),
    .mode_i     (mode),
    .last_i     (last),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input logic [1:0] mv, input logic lv);
    int n;
    a = av; b = bv; mode = mv; last = lv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 32'(out_valid), 32'd1);
    else            check(name, out_data, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] sat_exp;
`ifdef SCALABLE_MAC_SATURATE_EN
    sat_exp = 32'h7F7F7F7F;
`else
    sat_exp = 32'hA0A0A0A0;
`endif
    vecs[0] = '{"full_fd_07",  8'hFD, 8'h07, 2'b00, 32'hFFFFFFEB};
    vecs[1] = '{"half_3f_22",  8'h3F, 8'h22, 2'b10, 32'h0006FFFE};
    vecs[2] = '{"quar_79_ff",  8'h79, 8'hFF, 2'b01, 32'hFF0102FF};
    vecs[3] = '{"full_80_80",  8'h80, 8'h80, 2'b00, 32'h00004000};
    vecs[4] = '{"full_7f_80",  8'h7F, 8'h80, 2'b00, 32'hFFFFC080};
    vecs[5] = '{"half_88_88",  8'h88, 8'h88, 2'b10, 32'h00400040};
    vecs[6] = '{"half_7f_81",  8'h7F, 8'h81, 2'b10, 32'hFFC8FFFF};
    vecs[7] = '{"quar11_aa55", 8'hAA, 8'h55, 2'b11, 32'hFEFEFEFE};

    rst_n = 1'b0; a = '0; b = '0; mode = '0; last = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat table: valid must be low one cycle after acceptance, high the next.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].mode, 1'b1);
      check({vecs[i].name, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check(vecs[i].name, out_data, vecs[i].exp);
      @(negedge clk);
    end
    send(8'h1B, 8'hE4, 2'b01, 1'b1);
    wait_result("quar_1b_e4", 32'h00FEFE00);

    // Full-mode three-beat accumulation, back to back.
    send(8'd100, 8'd100, 2'b00, 1'b0);
    send(8'd100, 8'd100, 2'b00, 1'b0);
    send(8'd100, 8'd100, 2'b00, 1'b1);
    wait_result("acc_full_3x100", 32'h00007530);

    // Quarter-mode 40 beats: each lane 40*4 wraps or saturates.
    for (int i = 0; i < 40; i++) send(8'hAA, 8'hAA, 2'b01, (i == 39));
    wait_result("acc_quar_40xaa", sat_exp);

    // Backpressure with a pending result and a mode change mid-accumulation.
    out_ready = 1'b0;
    send(8'd5, 8'd6, 2'b00, 1'b1);
    send(8'h11, 8'h11, 2'b10, 1'b0);
    a = 8'h11; b = 8'h11; mode = 2'b01; last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_c%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_data_c%0d", i), out_data, 32'h0000001E);
      check($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_after_handshake", 32'(out_valid), 32'd0);
    wait_result("bp_half_latched", 32'h00020002);

    // Reset after two of three beats; next result must not include them.
    send(8'd10, 8'd10, 2'b00, 1'b0);
    send(8'd10, 8'd10, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h21, 8'h13, 2'b10, 1'b1);
    wait_result("rst_fresh_half", 32'h00020003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
